// File: rtl/ram_decoder_loader_pkg.sv
// Shared types and constants for the runtime-loadable decoder RAM.
package ram_decoder_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          DECODER_DEPTH   = 512;
    localparam logic [7:0]  CHECKSUM_TARGET = 8'h00;

endpackage

// File: rtl/ram_decoder_sdp.sv
// Simple dual-port RAM: synchronous write, clock-enabled registered read (read-before-write).
module ram_decoder_sdp #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     write_enable_i,
    input  logic [ADDRESS_WIDTH-1:0] write_address_i,
    input  logic [DATA_WIDTH-1:0]    write_data_i,
    input  logic                     read_enable_i,
    input  logic [ADDRESS_WIDTH-1:0] read_address_i,
    output logic [DATA_WIDTH-1:0]    read_data_o
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] read_data_d;
    logic [DATA_WIDTH-1:0] read_data_q;

    // Array write port; the array itself is never reset.
    always_ff @(posedge clock_i) begin
        if (write_enable_i) begin
            mem_q[write_address_i] <= write_data_i;
        end
    end

    // Read data holds while the enable is low.
    always_comb begin
        read_data_d = read_data_q;
        if (read_enable_i) begin
            read_data_d = mem_q[read_address_i];
        end else begin
            read_data_d = read_data_q;
        end
    end

    // Output register: reset clears only the read data, not the array.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            read_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign read_data_o = read_data_q;

endmodule

// File: rtl/ram_decoder_loader.sv
// Loads a decoder image from a byte stream into RAM, verifies the trailing checksum, serves reads.
module ram_decoder_loader
    import ram_decoder_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [DATA_WIDTH-1:0]    stream_data_i,
    input  logic                     stream_valid_i,
    output logic                     stream_ready_o,
    output logic                     loaded_o,
    output logic                     error_o,
    input  logic                     clock_enable_i,
    input  logic [ADDRESS_WIDTH-1:0] address_i,
    output logic [DATA_WIDTH-1:0]    data_o
);

    state_e                  state_q, state_d;
    logic [ADDRESS_WIDTH:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic                    loaded_q, loaded_d;
    logic                    error_q, error_d;
    logic                    ready_q, ready_d;
    logic                    accept_s;
    logic                    write_enable_s;
    logic [DATA_WIDTH-1:0]   sum_next_s;

    function automatic logic checksum_ok(input logic [DATA_WIDTH-1:0] total);
        return total == DATA_WIDTH'(CHECKSUM_TARGET);
    endfunction

    assign accept_s   = stream_valid_i && ready_q;
    assign sum_next_s = sum_q + stream_data_i;
    // The top counter bit marks the checksum byte, which never reaches the RAM.
    assign write_enable_s = accept_s && !count_q[ADDRESS_WIDTH] && !reset_i;

    // Loader FSM: next state, byte counter, running sum and result flags.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sum_d    = sum_q;
        loaded_d = loaded_q;
        error_d  = error_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d  = LOAD;
                    count_d  = {(ADDRESS_WIDTH+1){1'b0}};
                    sum_d    = {DATA_WIDTH{1'b0}};
                    loaded_d = 1'b0;
                    error_d  = 1'b0;
                end else begin
                    state_d  = state_q;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    sum_d = sum_next_s;
                    if (count_q[ADDRESS_WIDTH]) begin
                        state_d = DONE;
                        if (checksum_ok(sum_next_s)) begin
                            loaded_d = 1'b1;
                        end else begin
                            error_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q + (ADDRESS_WIDTH+1)'(1);
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == LOAD);
    end

    // State and flag registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            count_q  <= {(ADDRESS_WIDTH+1){1'b0}};
            sum_q    <= {DATA_WIDTH{1'b0}};
            loaded_q <= 1'b0;
            error_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            loaded_q <= loaded_d;
            error_q  <= error_d;
            ready_q  <= ready_d;
        end
    end

    ram_decoder_sdp #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .write_enable_i  (write_enable_s),
        .write_address_i (count_q[ADDRESS_WIDTH-1:0]),
        .write_data_i    (stream_data_i),
        .read_enable_i   (clock_enable_i),
        .read_address_i  (address_i),
        .read_data_o     (data_o)
    );

    assign stream_ready_o = ready_q;
    assign loaded_o       = loaded_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_ram_decoder_loader.sv
// Directed self-checking bench for ram_decoder_loader.
module tb_ram_decoder_loader;
    import ram_decoder_loader_pkg::*;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] stream_data_i = 8'h00;
    logic       stream_valid_i = 1'b0;
    logic       stream_ready_o;
    logic       loaded_o;
    logic       error_o;
    logic       clock_enable_i = 1'b0;
    logic [8:0] address_i = 9'h000;
    logic [7:0] data_o;

    int errors = 0;
    int checks = 0;
    int accepted;

    ram_decoder_loader #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .stream_data_i  (stream_data_i),
        .stream_valid_i (stream_valid_i),
        .stream_ready_o (stream_ready_o),
        .loaded_o       (loaded_o),
        .error_o        (error_o),
        .clock_enable_i (clock_enable_i),
        .address_i      (address_i),
        .data_o         (data_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_load();
        @(negedge clock_i);
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        check_value("start_ready", stream_ready_o, 1'b1);
        check_value("start_loaded_clr", loaded_o, 1'b0);
        check_value("start_error_clr", error_o, 1'b0);
    endtask

    // Streams one image (optionally inverted) plus checksum; hooks for start pulse, reset and a read.
    task automatic stream_image(input bit inv, input logic [7:0] cksum, input bit gaps,
                                input int pulse_at, input int reset_at, input int read_at,
                                input logic [7:0] read_exp, output int n_acc);
        int  idx = 0;
        int  cycles = 0;
        bit  pulsed = 1'b0;
        bit  read_pending = 1'b0;
        logic [7:0] b;
        n_acc = 0;
        while (idx < DECODER_DEPTH + 1 && cycles < 5000) begin
            @(negedge clock_i);
            cycles++;
            if (read_pending) begin
                check_value("rd_during_wr_old", data_o, read_exp);
                read_pending = 1'b0;
            end
            start_i = 1'b0;
            clock_enable_i = 1'b0;
            if (idx == reset_at) begin
                reset_i = 1'b1;
                stream_valid_i = 1'b0;
                break;
            end
            b = (idx < DECODER_DEPTH) ? 8'(idx) : cksum;
            stream_data_i = (inv && idx < DECODER_DEPTH) ? ~b : b;
            stream_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == pulse_at && !pulsed) begin
                start_i = 1'b1;
                pulsed = 1'b1;
            end
            if (idx == read_at && stream_ready_o && stream_valid_i && !read_pending) begin
                address_i = 9'(read_at);
                clock_enable_i = 1'b1;
                read_pending = 1'b1;
            end
            if (stream_valid_i && stream_ready_o) begin
                idx++;
                n_acc++;
            end
        end
        check_value("stream_timeout", cycles < 5000, 1'b1);
        @(negedge clock_i);
        stream_valid_i = 1'b0;
        start_i = 1'b0;
        reset_i = 1'b0;
        clock_enable_i = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [8:0] addr, input logic [7:0] exp);
        @(negedge clock_i);
        address_i = addr;
        clock_enable_i = 1'b1;
        @(negedge clock_i);
        clock_enable_i = 1'b0;
        check_value(tag, data_o, exp);
    endtask

    initial begin
        logic [8:0] a;
        reset_i = 1'b1;
        repeat (3) @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        check_value("rst_ready", stream_ready_o, 1'b0);
        check_value("rst_loaded", loaded_o, 1'b0);
        check_value("rst_error", error_o, 1'b0);
        check_value("rst_data", data_o, 8'h00);

        // Full load without gaps.
        start_load();
        stream_image(1'b0, 8'h00, 1'b0, -1, -1, -1, 8'h00, accepted);
        check_value("full_accepts", accepted, 513);
        check_value("full_ready", stream_ready_o, 1'b0);
        check_value("full_loaded", loaded_o, 1'b1);
        check_value("full_error", error_o, 1'b0);
        read_check("rd_1ff", 9'h1FF, 8'hFF);
        read_check("rd_105", 9'h105, 8'h05);

        // Enable low: data holds while the address moves.
        read_check("rd_1ff_again", 9'h1FF, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock_i);
            address_i = 9'(k * 100 + 5);
            clock_enable_i = 1'b0;
            @(negedge clock_i);
            check_value("ce_low_hold", data_o, 8'hFF);
        end

        // Reload with inverted image, reading 0x010 on the edge it is rewritten.
        start_load();
        stream_image(1'b1, 8'h00, 1'b0, -1, -1, 16, 8'h10, accepted);
        check_value("inv_loaded", loaded_o, 1'b1);
        read_check("inv_rd_010", 9'h010, 8'hEF);
        read_check("inv_rd_1ff", 9'h1FF, 8'h00);

        // Bad checksum.
        start_load();
        stream_image(1'b0, 8'h01, 1'b0, -1, -1, -1, 8'h00, accepted);
        check_value("bad_error", error_o, 1'b1);
        check_value("bad_loaded", loaded_o, 1'b0);
        check_value("bad_ready", stream_ready_o, 1'b0);
        repeat (3) @(negedge clock_i);
        check_value("bad_error_hold", error_o, 1'b1);
        check_value("bad_ready_hold", stream_ready_o, 1'b0);

        // Gapped stream.
        start_load();
        stream_image(1'b0, 8'h00, 1'b1, -1, -1, -1, 8'h00, accepted);
        check_value("gap_accepts", accepted, 513);
        check_value("gap_loaded", loaded_o, 1'b1);
        check_value("gap_error", error_o, 1'b0);
        for (int i = 0; i < DECODER_DEPTH; i++) begin
            a = 9'(i);
            read_check("gap_ram", a, 8'(i));
        end

        // Reset after 100 accepted bytes, then a clean reload.
        start_load();
        stream_image(1'b0, 8'h00, 1'b0, -1, 100, -1, 8'h00, accepted);
        check_value("rst_mid_accepts", accepted, 100);
        check_value("rst_mid_ready", stream_ready_o, 1'b0);
        check_value("rst_mid_loaded", loaded_o, 1'b0);
        check_value("rst_mid_data", data_o, 8'h00);
        start_load();
        stream_image(1'b0, 8'h00, 1'b0, -1, -1, -1, 8'h00, accepted);
        check_value("after_rst_loaded", loaded_o, 1'b1);

        // start_i during LOAD is ignored.
        start_load();
        stream_image(1'b0, 8'h00, 1'b0, 300, -1, -1, 8'h00, accepted);
        check_value("pulse_accepts", accepted, 513);
        check_value("pulse_loaded", loaded_o, 1'b1);
        check_value("pulse_error", error_o, 1'b0);
        check_value("pulse_ready", stream_ready_o, 1'b0);
        read_check("pulse_rd_12c", 9'h12C, 8'h2C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
